// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux stream multiplexer.
// Mode encodings select the arbitration policy at elaboration time.
package arb_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int MODE_SEL   = 2;

  // Smallest r with 2**r >= n, usable in parameter declarations.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// One-hot arbiter: the first requester at or after ptr (wrapping) wins.
// With ptr tied to zero it degenerates to fixed priority, lowest index first.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IDW = clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] ptr,
  output logic [NCH-1:0] gnt,
  output logic [IDW-1:0] gnt_idx
);

  logic [NCH-1:0] rot;
  logic           hit;
  int             win;

  // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    hit     = 1'b0;
    win     = 0;
    rot     = NCH'({req, req} >> ptr);
    for (int j = NCH - 1; j >= 0; j--) begin
      if (rot[j]) begin
        hit = 1'b1;
        win = j;
      end
    end
    // Rotated offset back to an absolute channel; explicit compare keeps non-power-of-two NCH correct.
    win = win + int'(ptr);
    if (win >= NCH) win = win - NCH;
    if (hit) begin
      gnt_idx = IDW'(win);
      for (int i = 0; i < NCH; i++) gnt[i] = (i == win);
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel valid/ready stream multiplexer with a one-entry registered output stage.
// Arbitration is fixed priority, round-robin or external select depending on MODE.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int MODE  = MODE_FIXED,
  parameter int IDW   = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [IDW-1:0]       sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDW-1:0]       out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic           ld;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] arb_ptr;
  logic [NCH-1:0] rr_gnt;
  logic [IDW-1:0] rr_idx;
  logic [NCH-1:0] grant;
  logic [IDW-1:0] grant_idx;
  logic           any_acc;
  logic [WIDTH-1:0] mux_data;

  assign ld      = ~out_valid | out_ready;
  assign arb_ptr = (MODE == MODE_RR) ? ptr : '0;

  rr_arbiter #(
    .NCH (NCH),
    .IDW (IDW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (arb_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  always_comb begin
    grant     = rr_gnt;
    grant_idx = rr_idx;
    if (MODE == MODE_SEL) begin
      grant     = '0;
      grant_idx = sel;
      if (int'(sel) < NCH) begin
        for (int i = 0; i < NCH; i++) grant[i] = in_valid[i] && (int'(sel) == i);
      end
    end
  end

  // Gating with rst_n keeps producers from seeing a handshake while the block is held in reset.
  assign in_ready = grant & {NCH{ld & rst_n}};
  assign any_acc  = |in_ready;

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NCH; i++) begin
      mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (ld) begin
        out_valid <= any_acc;
        if (any_acc) begin
          out_data <= mux_data;
          out_ch   <= grant_idx;
        end
      end
      if (MODE == MODE_RR && any_acc) begin
        ptr <= (grant_idx == IDW'(NCH - 1)) ? '0 : grant_idx + IDW'(1);
      end
    end
  end

endmodule
